// File: rtl/tb_douta_mapper_if.sv
// Command/data bundle between the scheduler/BRAM side and the TB port-A lane mapper.
interface tb_douta_mapper_if #(
  parameter int X      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 16,
  parameter int NDEST  = 2,
  parameter int LEN_W  = 8,
  localparam int DEST_W = (NDEST > 1) ? $clog2(NDEST) : 1,
  localparam int ROT_W  = (L > 1) ? $clog2(L) : 1
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [DEST_W-1:0]           cmd_dest;
  logic [2:0]                  cmd_dir;
  logic [LEN_W-1:0]            cmd_len;
  logic                        cmd_half0;
  logic [ROT_W-1:0]            cmd_rot;
  logic                        douta_valid;
  logic [L*RSA_DW-1:0]         TB_douta;
  logic [NDEST*X*RSA_DW-1:0]   map_douta;
  logic [NDEST-1:0]            map_valid;
  logic                        busy;
  logic                        done;

  modport master (
    output cmd_valid, cmd_dest, cmd_dir, cmd_len, cmd_half0, cmd_rot, douta_valid, TB_douta,
    input  cmd_ready, map_douta, map_valid, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_dest, cmd_dir, cmd_len, cmd_half0, cmd_rot, douta_valid, TB_douta,
    output cmd_ready, map_douta, map_valid, busy, done
  );
endinterface

// File: rtl/tb_douta_mapper.sv
// Command-driven TB port-A lane mapper: routes L-lane BRAM read beats onto one of NDEST X-lane buses.
// Optional TB_MAP_LAST_HOLD_EN: selected bus holds its last mapped value across RUN valid gaps.
module tb_douta_mapper #(
  parameter int X      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 16,
  parameter int NDEST  = 2,
  parameter int NEW_W  = 2,
  parameter int LEN_W  = 8
) (
  input  logic               clk,
  input  logic               sys_rst,
  tb_douta_mapper_if.slave   bus
);
  localparam int DEST_W = (NDEST > 1) ? $clog2(NDEST) : 1;
  localparam int ROT_W  = (L > 1) ? $clog2(L) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                                  state_q, state_d;
  logic [DEST_W-1:0]                       dest_q, dest_d;
  logic [2:0]                              dir_q, dir_d;
  logic [LEN_W-1:0]                        len_q, len_d;
  logic [LEN_W-1:0]                        cnt_q, cnt_d;
  logic [ROT_W-1:0]                        rot_q, rot_d;
  logic                                    half_q, half_d;
  logic                                    done_q, done_d;
  logic [NDEST-1:0][X-1:0][RSA_DW-1:0]     map_q, map_d;
  logic [NDEST-1:0]                        mvld_q, mvld_d;

  logic [L-1:0][RSA_DW-1:0]                din;
  logic [X-1:0][RSA_DW-1:0]                lane;
  logic                                    beat, mode_act;

  assign din      = bus.TB_douta;
  assign beat     = (state_q == S_RUN) && bus.douta_valid;
  assign mode_act = (dir_q >= 3'd1) && (dir_q <= 3'd5);

  for (genvar i = 0; i < X; i++) begin : g_lane
    logic [ROT_W-1:0]  ridx;
    logic [RSA_DW-1:0] nw, v;
    assign ridx = ROT_W'((i + int'(rot_q)) % L);
    // NEW mode only drives the first NEW_W lanes; half=1 picks the low input lanes.
    if (i < NEW_W) begin : g_new
      assign nw = half_q ? din[i] : din[NEW_W+i];
    end else begin : g_nonew
      assign nw = '0;
    end
    always_comb begin
      v = '0;
      case (dir_q)
        3'b001:  v = din[i];
        3'b010:  v = din[X-1-i];
        3'b011:  v = nw;
        3'b100:  v = din[ridx];
        3'b101:  v = din[rot_q];
        default: v = '0;
      endcase
    end
    assign lane[i] = v;
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    dir_d   = dir_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    half_d  = half_q;
    done_d  = 1'b0;
    map_d   = '0;
    mvld_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          dest_d = bus.cmd_dest;
          dir_d  = bus.cmd_dir;
          len_d  = bus.cmd_len;
          rot_d  = bus.cmd_rot;
          half_d = bus.cmd_half0;
          cnt_d  = '0;
          if (bus.cmd_len != '0) state_d = S_RUN;
          else                   done_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.douta_valid) begin
          cnt_d  = cnt_q + LEN_W'(1);
          half_d = ~half_q;
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    for (int d = 0; d < NDEST; d++) begin
      if ((state_q == S_RUN) && (dest_q == DEST_W'(d))) begin
        if (beat) begin
          map_d[d]  = mode_act ? lane : '0;
          mvld_d[d] = mode_act;
        end else begin
`ifdef TB_MAP_LAST_HOLD_EN
          map_d[d] = map_q[d];
`else
          map_d[d] = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      dest_q  <= '0;
      dir_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rot_q   <= '0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
      map_q   <= '0;
      mvld_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      half_q  <= half_d;
      done_q  <= done_d;
      map_q   <= map_d;
      mvld_q  <= mvld_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = done_q;
  assign bus.map_douta = map_q;
  assign bus.map_valid = mvld_q;
endmodule

// File: tb/tb_tb_douta_mapper.sv
// Directed bench for tb_douta_mapper: hand-computed lane maps, burst timing, len=0, reset abort.
module tb_tb_douta_mapper;
  localparam int X = 4, L = 4, RSA_DW = 16, NDEST = 2, NEW_W = 2, LEN_W = 8;
  localparam int LBW = X*RSA_DW;
  localparam int BW  = NDEST*LBW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tb_douta_mapper_if #(.X(X), .L(L), .RSA_DW(RSA_DW), .NDEST(NDEST), .LEN_W(LEN_W)) bus ();

  tb_douta_mapper #(.X(X), .L(L), .RSA_DW(RSA_DW), .NDEST(NDEST), .NEW_W(NEW_W), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .sys_rst (rst),
    .bus     (bus.slave)
  );

  localparam logic [LBW-1:0] D4321 = {16'h4, 16'h3, 16'h2, 16'h1};
  localparam logic [LBW-1:0] DDCBA = {16'hD, 16'hC, 16'hB, 16'hA};

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] onbus(input int d, input logic [LBW-1:0] v);
    logic [BW-1:0] r;
    r = '0;
    if (d == 0) r[LBW-1:0] = v;
    else        r[BW-1:LBW] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single cycle; the FSM must be idle.
  task automatic cmd(input int dest, input int dir, input int len, input bit half0, input int rot);
    bus.cmd_valid = 1'b1;
    bus.cmd_dest  = 1'(dest);
    bus.cmd_dir   = 3'(dir);
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_half0 = half0;
    bus.cmd_rot   = 2'(rot);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    logic [LBW-1:0] prev;
    bus.cmd_valid = 0; bus.cmd_dest = 0; bus.cmd_dir = 0; bus.cmd_len = 0;
    bus.cmd_half0 = 0; bus.cmd_rot = 0; bus.douta_valid = 0; bus.TB_douta = '0;
    tick(); tick();
    chk("rst_ready", BW'(bus.cmd_ready), 1);
    chk("rst_busy",  BW'(bus.busy), 0);
    chk("rst_done",  BW'(bus.done), 0);
    chk("rst_map",   bus.map_douta, '0);
    chk("rst_vld",   BW'(bus.map_valid), 0);
    rst = 1'b0;
    tick();

    // POS to A, 3 back-to-back beats
    cmd(0, 1, 3, 0, 0);
    chk("pos_busy",  BW'(bus.busy), 1);
    chk("pos_rdy",   BW'(bus.cmd_ready), 0);
    bus.douta_valid = 1; bus.TB_douta = D4321;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pos_map",  bus.map_douta, onbus(0, D4321));
      chk("pos_vld",  BW'(bus.map_valid), 1);
      chk("pos_done", BW'(bus.done), (k == 2) ? 1 : 0);
    end
    chk("pos_rdy_end", BW'(bus.cmd_ready), 1);
    bus.douta_valid = 0;
    tick();
    chk("pos_done_clr", BW'(bus.done), 0);
    chk("pos_map_clr",  bus.map_douta, '0);

    // NEG to M
    cmd(1, 2, 1, 0, 0);
    bus.douta_valid = 1; bus.TB_douta = DDCBA;
    tick();
    bus.douta_valid = 0;
    chk("neg_map",  bus.map_douta, onbus(1, {16'hA, 16'hB, 16'hC, 16'hD}));
    chk("neg_vld",  BW'(bus.map_valid), 2);
    chk("neg_done", BW'(bus.done), 1);
    tick();

    // NEW mode with gaps between beats
    cmd(0, 3, 4, 1, 0);
    bus.TB_douta = D4321;
    for (int k = 0; k < 4; k++) begin
      bus.douta_valid = 1;
      tick();
      prev = (k % 2 == 0) ? {32'h0, 16'h2, 16'h1} : {32'h0, 16'h4, 16'h3};
      chk("new_map",  bus.map_douta, onbus(0, prev));
      chk("new_vld",  BW'(bus.map_valid), 1);
      chk("new_done", BW'(bus.done), (k == 3) ? 1 : 0);
      if (k < 3) begin
        bus.douta_valid = 0;
        tick();
`ifdef TB_MAP_LAST_HOLD_EN
        chk("gap_map", bus.map_douta, onbus(0, prev));
`else
        chk("gap_map", bus.map_douta, '0);
`endif
        chk("gap_vld",  BW'(bus.map_valid), 0);
        chk("gap_busy", BW'(bus.busy), 1);
        chk("gap_done", BW'(bus.done), 0);
      end
    end
    bus.douta_valid = 0;
    tick();

    // ROT, BCAST, reserved
    cmd(0, 4, 1, 0, 1);
    bus.douta_valid = 1; tick(); bus.douta_valid = 0;
    chk("rot_map", bus.map_douta, onbus(0, {16'h1, 16'h4, 16'h3, 16'h2}));
    cmd(1, 5, 1, 0, 2);
    bus.douta_valid = 1; tick(); bus.douta_valid = 0;
    chk("bc_map", bus.map_douta, onbus(1, {16'h3, 16'h3, 16'h3, 16'h3}));
    chk("bc_vld", BW'(bus.map_valid), 2);
    cmd(0, 7, 1, 0, 0);
    bus.douta_valid = 1; tick(); bus.douta_valid = 0;
    chk("rsv_map",  bus.map_douta, '0);
    chk("rsv_vld",  BW'(bus.map_valid), 0);
    chk("rsv_done", BW'(bus.done), 1);

    // len=0, then a command taken while done is high
    cmd(0, 1, 0, 0, 0);
    chk("z_done", BW'(bus.done), 1);
    chk("z_vld",  BW'(bus.map_valid), 0);
    chk("z_rdy",  BW'(bus.cmd_ready), 1);
    cmd(0, 1, 1, 0, 0);
    chk("b2b_busy", BW'(bus.busy), 1);
    chk("b2b_done", BW'(bus.done), 0);
    bus.douta_valid = 1; tick(); bus.douta_valid = 0;
    chk("b2b_map",  bus.map_douta, onbus(0, D4321));
    chk("b2b_fin",  BW'(bus.done), 1);
    tick();

    // reset mid-burst
    cmd(0, 1, 5, 0, 0);
    bus.douta_valid = 1; tick(); tick();
    rst = 1'b1; tick();
    chk("ab_map",  bus.map_douta, '0);
    chk("ab_vld",  BW'(bus.map_valid), 0);
    chk("ab_rdy",  BW'(bus.cmd_ready), 1);
    chk("ab_done", BW'(bus.done), 0);
    rst = 1'b0; bus.douta_valid = 0; tick();
    chk("ab_done2", BW'(bus.done), 0);
    cmd(1, 1, 1, 0, 0);
    bus.douta_valid = 1; tick(); bus.douta_valid = 0;
    chk("ab_new_map",  bus.map_douta, onbus(1, D4321));
    chk("ab_new_done", BW'(bus.done), 1);
    tick();
    chk("ab_idle", BW'(bus.cmd_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
